sar_conversion_scheduler: RTL
=============================

# sar_conversion_scheduler

Multi-channel sequencer for the SAR ADC core. Each conversion selects an analog mux channel, holds the sample-and-hold in track for a fixed settling window, then gates the SAR comparison for exactly one full conversion. It captures the code and delivers it with its channel index over a valid/ready stream. It sits between the system register interface (start, continuous mode, channel mask) and the SAR register/comparator pair.

## Interface
Parameters:
- N_BITS, 10, SAR resolution
- N_CH, 4, number of analog mux inputs (≥2)
- SETTLE_CYCLES, 3, track/settle cycles per channel (≥1)

Ports (CH_W = $clog2(N_CH)):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a scan; honoured only in IDLE
- continuous  in  1  rescan after the last channel instead of stopping
- chan_enable  in  N_CH  channel mask; bit i enables channel i
- mux_sel  out  CH_W  analog mux select
- sample_hold  out  1  1 = track, 0 = hold
- sar_conduct  out  1  drives the SAR conduct_comparison input
- sar_feedback  in  1  comparator output, same signal fed to the SAR
- sar_result  in  N_BITS  SAR quantized_voltage
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_data  out  N_BITS  converted code
- out_channel  out  CH_W  channel of out_data
- busy  out  1  state ≠ IDLE
- scan_done  out  1  one-cycle pulse when a non-continuous scan ends

## Operation
- States: IDLE, SETTLE, CONVERT, DELIVER.
- IDLE + start + chan_enable≠0: snapshot chan_enable into scan_mask, select its lowest set bit, go to SETTLE. A start with a zero mask is ignored. start outside IDLE is ignored.
- SETTLE: mux_sel = current channel, sample_hold = 1. Lasts exactly SETTLE_CYCLES cycles, then goes to CONVERT.
- CONVERT: sample_hold = 0, sar_conduct = 1 for exactly 2*N_BITS cycles. On the final cycle, capture out_data = {sar_result[N_BITS-1:1], sar_feedback}; the LSB comes from the comparator directly. Then go to DELIVER.
- DELIVER: out_valid = 1. out_data and out_channel stay stable until out_valid && out_ready. After the handshake:
  - If a higher set bit remains in scan_mask, select it and go to SETTLE.
  - Otherwise, if continuous = 1: re-snapshot the live chan_enable. If it is non-zero, go to SETTLE on its lowest bit; if it is zero, go to IDLE and pulse scan_done.
  - Otherwise go to IDLE and pulse scan_done.
- Mask changes during a scan have no effect until the next snapshot.
- Clearing continuous mid-scan ends the scan after its last channel.
- No conversion is dropped. The scheduler stalls in DELIVER for as long as out_ready is low.
- Reset at any point: state = IDLE. All outputs 0 (mux_sel = 0, sample_hold = 0, sar_conduct = 0, out_valid = 0, out_data = 0, out_channel = 0, busy = 0, scan_done = 0). Internal counters and scan_mask are cleared.

## Timing
- Let cycle 0 be the edge where IDLE samples start. Then:
  - SETTLE occupies cycles 1..S.
  - CONVERT occupies cycles S+1..S+2N.
  - out_valid first rises in cycle S+2N+1.
  - With the defaults, out_valid rises in cycle 24.
- Handshake edge k means SETTLE for the next channel begins in cycle k+1. Per-channel period = S+2N+1 cycles, plus any stall.
- sar_conduct is low for at least S cycles between conversions, which keeps the SAR bit counter aligned.
- scan_done is asserted in the first IDLE cycle after the final handshake.
- A start in that same IDLE cycle is accepted.
- All outputs are registered. sar_conduct, sample_hold and mux_sel never glitch within a state.

## Structure
- Package sar_sched_pkg holds:
  - the state enum type
  - localparams CONV_CYCLES = 2*N_BITS and CNT_W = $clog2(max(CONV_CYCLES, SETTLE_CYCLES)+1)
- One natural sub-module, sar_next_channel: combinational. Inputs: mask, current index, "from start" flag. Outputs: the next set bit strictly above the current index (or the lowest set bit), plus a found flag.
- A single shared cycle counter serves both SETTLE and CONVERT.

## Test plan
Defaults N_BITS=10, N_CH=4, S=3; the bench models the SAR with an ideal comparator.
- Single channel: mask 4'b0100, start, input 0.3·Vref, out_ready=1 -> one result with out_channel=2 and out_data=307±1 at cycle 24; scan_done at cycle 25; no further sar_conduct.
- Sparse scan: mask 4'b1011 -> results in channel order 0, 1, 3, handshakes 24 cycles apart; channel 2 never selected; scan_done once.
- Backpressure: out_ready held low for 50 cycles in DELIVER -> out_valid and out_data stable for all 50 cycles; the next SETTLE starts the cycle after out_ready rises.
- Continuous mode: mask 4'b0011 with continuous=1, mask changed to 4'b0100 mid-scan -> the sequence is 0, 1, then 2, 2, …. Clearing continuous ends the scan after the current channel with scan_done.
- Degenerate start: start with mask 0 -> stays IDLE, busy=0, no scan_done. start pulsed during CONVERT -> ignored; result count unchanged.
- Reset mid-CONVERT: reset asserted at cycle 10 of CONVERT -> next cycle all outputs 0, state IDLE. A subsequent start produces a correct conversion.

Source files
------------

// File: rtl/sar_conversion_scheduler_pkg.sv
// Shared types and sizing helpers for the SAR conversion scheduler.
package sar_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    // A packaged constant cannot follow a module parameter, so the sizes come from these helpers.
    function automatic int conv_cycles(input int n_bits);
        return 2 * n_bits;
    endfunction

    function automatic int cnt_width(input int conv, input int settle);
        int longest;
        longest = (conv > settle) ? conv : settle;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sar_conversion_scheduler_if.sv
// Result stream carrying one converted code and its channel index.
interface sar_conversion_scheduler_if #(
    parameter int N_BITS = 10,
    parameter int N_CH   = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_data;
    logic [CH_W-1:0]   out_channel;

    modport master (
        output out_valid,
        output out_data,
        output out_channel,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_channel,
        output out_ready
    );
endinterface

// File: rtl/sar_conversion_scheduler_next_channel.sv
// Picks the next enabled channel: the lowest set bit, or the lowest set bit above cur.
module sar_next_channel #(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W-1:0] cur,
    input  logic            from_start,
    output logic [CH_W-1:0] next,
    output logic            found
);
    // Scan downward so the last qualifying hit is the lowest index.
    always_comb begin
        next  = '0;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                next  = CH_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sar_conversion_scheduler.sv
// Sequences mux select, track/hold and SAR conversion windows across enabled channels.
module sar_conversion_scheduler
    import sar_sched_pkg::*;
#(
    parameter  int N_BITS        = 10,
    parameter  int N_CH          = 4,
    parameter  int SETTLE_CYCLES = 3,
    localparam int CH_W          = $clog2(N_CH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          continuous,
    input  logic [N_CH-1:0]               chan_enable,
    output logic [CH_W-1:0]               mux_sel,
    output logic                          sample_hold,
    output logic                          sar_conduct,
    input  logic                          sar_feedback,
    input  logic [N_BITS-1:0]             sar_result,
    output logic                          busy,
    output logic                          scan_done,
    sar_conversion_scheduler_if.master    out_if
);
    localparam int CONV_CYCLES = conv_cycles(N_BITS);
    localparam int CNT_W       = cnt_width(CONV_CYCLES, SETTLE_CYCLES);

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
    localparam logic [N_BITS-1:0] LSB_MASK    = N_BITS'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   cur_ch;
    logic [N_CH-1:0]   scan_mask;

    logic [CH_W-1:0]   first_ch;
    logic              first_found;
    logic [CH_W-1:0]   higher_ch;
    logic              higher_found;

    // Lowest enabled channel of the live mask, used for every new snapshot.
    sar_next_channel #(.N_CH(N_CH)) u_first (
        .mask       (chan_enable),
        .cur        ('0),
        .from_start (1'b1),
        .next       (first_ch),
        .found      (first_found)
    );

    sar_next_channel #(.N_CH(N_CH)) u_higher (
        .mask       (scan_mask),
        .cur        (cur_ch),
        .from_start (1'b0),
        .next       (higher_ch),
        .found      (higher_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            cur_ch             <= '0;
            scan_mask          <= '0;
            mux_sel            <= '0;
            sample_hold        <= 1'b0;
            sar_conduct        <= 1'b0;
            busy               <= 1'b0;
            scan_done          <= 1'b0;
            out_if.out_valid   <= 1'b0;
            out_if.out_data    <= '0;
            out_if.out_channel <= '0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && first_found) begin
                        scan_mask   <= chan_enable;
                        cur_ch      <= first_ch;
                        mux_sel     <= first_ch;
                        sample_hold <= 1'b1;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt         <= '0;
                        sample_hold <= 1'b0;
                        sar_conduct <= 1'b1;
                        state       <= ST_CONVERT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (cnt == CONV_LAST) begin
                        cnt                <= '0;
                        sar_conduct        <= 1'b0;
                        out_if.out_valid   <= 1'b1;
                        // LSB is still being decided in the SAR register; take it from the comparator.
                        out_if.out_data    <= (sar_result & ~LSB_MASK) | N_BITS'(sar_feedback);
                        out_if.out_channel <= cur_ch;
                        state              <= ST_DELIVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DELIVER: begin
                    if (out_if.out_valid && out_if.out_ready) begin
                        out_if.out_valid <= 1'b0;
                        if (higher_found) begin
                            cur_ch      <= higher_ch;
                            mux_sel     <= higher_ch;
                            sample_hold <= 1'b1;
                            state       <= ST_SETTLE;
                        end else if (continuous && first_found) begin
                            scan_mask   <= chan_enable;
                            cur_ch      <= first_ch;
                            mux_sel     <= first_ch;
                            sample_hold <= 1'b1;
                            state       <= ST_SETTLE;
                        end else begin
                            if (continuous) begin
                                scan_mask <= chan_enable;
                            end
                            mux_sel   <= '0;
                            busy      <= 1'b0;
                            scan_done <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
